uart_frame_decoder: RTL and testbench
=====================================

// Module: uart_frame_decoder
// PURPOSE
//   Receive-side decoder for the 2-byte UART key frame [HEADER, payload] sent by the board-level
//   keyboard path. Consumes the byte stream from uart_rx (data/rx_done) and validates framing.
//   Buffers decoded payload bytes in a small FWFT FIFO for downstream consumers.
//   Holds the most recent payload for the seven_segment display (num1=[7:4], num2=[3:0]).
// PARAMETERS
//   HEADER          8'h01      frame start byte
//   TIMEOUT_CYCLES  1_000_000  max clk cycles between header and payload (10 ms @ 100 MHz), >=2
//   DEPTH           8          FIFO entries, power of two, >=2
//   AW              3          FIFO address width, log2(DEPTH)
// PORTS
//   clk           in   1   system clock
//   rst_n         in   1   asynchronous active-low reset
//   rx_byte       in   8   byte from uart_rx, valid only when rx_done=1
//   rx_done       in   1   one-cycle strobe: rx_byte valid
//   rd_en         in   1   pop FIFO head (ignored when empty)
//   rd_data       out  8   FIFO head, valid whenever empty=0 (first-word fall-through)
//   empty         out  1   FIFO empty
//   full          out  1   FIFO holds DEPTH entries
//   last_payload  out  8   most recently decoded payload (display source)
//   frame_err     out  1   one-cycle pulse: stray byte or payload timeout
//   overflow      out  1   one-cycle pulse: valid payload dropped because FIFO full
//   frame_count   out  16  count of valid frames decoded (incl. dropped), wraps 0xFFFF->0
// BEHAVIOUR
//   Reset (rst_n=0, async): state=IDLE, timer=0, FIFO ptrs/count=0, empty=1, full=0,
//     rd_data=0, last_payload=0, frame_err=0, overflow=0, frame_count=0. Mid-frame reset aborts
//     frame, no error pulse; FIFO contents discarded.
//   FSM, two states, all transitions on posedge clk:
//     IDLE: rx_done & rx_byte==HEADER -> PAYLOAD, timer<=0.
//           rx_done & rx_byte!=HEADER -> stay IDLE, frame_err=1 next cycle.
//     PAYLOAD: rx_done -> accept rx_byte as payload (any value, incl. HEADER; no escaping),
//           -> IDLE. Else timer<=timer+1; timer==TIMEOUT_CYCLES-1 -> IDLE, frame_err=1.
//           rx_done and timeout in same cycle: rx_done wins, no error.
//   Payload accept (edge E): last_payload<=byte, frame_count+=1; FIFO push if !full or rd_en;
//     if full & !rd_en: byte dropped, overflow=1 for one cycle. Latency: rx_done in cycle N ->
//     empty=0, rd_data valid in N+1.
//   FIFO: circular buffer, wr/rd ptrs AW bits wrap DEPTH-1->0; count AW+1 bits.
//     push&pop same cycle: both occur, count unchanged (also when full).
//     pop when empty: ignored, ptrs unchanged. push&pop when empty: push only.
//     rd_data is combinational read of mem[rd_ptr], 0 when empty.
//   frame_err and overflow are registered, never high for 2 consecutive cycles from one event.
// TESTING
//   1 rx_done bytes 01,41 -> empty falls 1 cycle after 2nd strobe, rd_data=41, last_payload=41,
//     frame_count=1; rd_en 1 cycle -> empty=1.
//   2 bytes 55, then 01,30 -> frame_err pulse after 55 only; FIFO holds 30, frame_count=1.
//   3 TIMEOUT_CYCLES=16: 01 then idle 16 cycles -> frame_err 1 pulse, state IDLE; next 01,7A
//     decodes 7A. Payload strobe at exactly cycle 15 -> no error, payload accepted.
//   4 DEPTH=8: 9 frames 01,n (n=0..8), no reads -> full after 8th, overflow pulse on 9th,
//     last_payload=08, frame_count=9; drain reads 00..07 in order then empty=1.
//   5 full FIFO, rd_en coincident with payload push -> no overflow, count stays 8, wrap ok.
//   6 assert rst_n=0 between 01 and payload -> all outputs reset values; payload byte after
//     release treated as stray (frame_err).

Source files
------------

// File: rtl/uart_frame_decoder.sv
// Decodes 2-byte [HEADER, payload] key frames from uart_rx, queues payloads in a
// first-word fall-through FIFO and holds the latest payload for the display.
module uart_frame_decoder #(
   parameter logic [7:0] HEADER         = 8'h01,
   parameter int         TIMEOUT_CYCLES = 1_000_000,
   parameter int         DEPTH          = 8,
   parameter int         AW             = 3
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [7:0]   rx_byte,
   input  logic         rx_done,
   input  logic         rd_en,
   output logic [7:0]   rd_data,
   output logic         empty,
   output logic         full,
   output logic [7:0]   last_payload,
   output logic         frame_err,
   output logic         overflow,
   output logic [15:0]  frame_count
);

   localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

   typedef enum logic {IDLE, PAYLOAD} state_t;

   state_t          state, state_next;
   logic [TW-1:0]   timer, timer_next;
   logic            err_next;
   logic            accept;
   logic            push, pop;

   logic [7:0]      mem [DEPTH];
   logic [AW-1:0]   wr_ptr, rd_ptr;
   logic [AW:0]     count;

   assign empty   = (count == '0);
   assign full    = (count == (AW+1)'(DEPTH));
   assign rd_data = empty ? 8'h00 : mem[rd_ptr];

   // A full FIFO still accepts a payload when the head leaves in the same cycle.
   assign push = accept & (~full | rd_en);
   assign pop  = rd_en & ~empty;

   // NOTE: every variable gets a default before the case, so no path leaves one unassigned and no latch is inferred.
   always_comb begin
      state_next = state;
      timer_next = timer;
      err_next   = 1'b0;
      accept     = 1'b0;
      case (state)
         IDLE: begin
            if (rx_done) begin
               if (rx_byte == HEADER) begin
                  state_next = PAYLOAD;
                  timer_next = '0;
               end else begin
                  err_next = 1'b1;
               end
            end
         end
         PAYLOAD: begin
            // A byte arriving on the last allowed cycle beats the timeout.
            if (rx_done) begin
               accept     = 1'b1;
               state_next = IDLE;
            end else if (timer == TW'(TIMEOUT_CYCLES - 1)) begin
               state_next = IDLE;
               err_next   = 1'b1;
            end else begin
               timer_next = timer + 1'b1;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= IDLE;
         timer        <= '0;
         frame_err    <= 1'b0;
         overflow     <= 1'b0;
         last_payload <= 8'h00;
         frame_count  <= 16'h0000;
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         count        <= '0;
      end else begin
         state     <= state_next;
         timer     <= timer_next;
         frame_err <= err_next;
         overflow  <= accept & full & ~rd_en;
         if (accept) begin
            last_payload <= rx_byte;
            frame_count  <= frame_count + 16'd1;
         end
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // NOTE: storage is not reset; pointers and count define validity, and rd_data is forced to 0 when empty.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= rx_byte;
   end

endmodule

// File: tb/tb_uart_frame_decoder.sv
// Directed bench for uart_frame_decoder: expected FIFO bytes go into a scoreboard
// queue and an independent monitor compares them as the DUT pops its head.
module tb_uart_frame_decoder;

   localparam logic [7:0] HDR = 8'h01;
   localparam int         TO  = 16;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [7:0]  rx_byte = 8'h00;
   logic        rx_done = 1'b0;
   logic        rd_en = 1'b0;
   logic [7:0]  rd_data;
   logic        empty, full, frame_err, overflow;
   logic [7:0]  last_payload;
   logic [15:0] frame_count;

   uart_frame_decoder #(
      .HEADER(HDR), .TIMEOUT_CYCLES(TO), .DEPTH(8), .AW(3)
   ) dut (
      .clk(clk), .rst_n(rst_n), .rx_byte(rx_byte), .rx_done(rx_done), .rd_en(rd_en),
      .rd_data(rd_data), .empty(empty), .full(full), .last_payload(last_payload),
      .frame_err(frame_err), .overflow(overflow), .frame_count(frame_count)
   );

   always #5 clk = ~clk;

   logic [7:0] sb[$];
   logic [7:0] exp_byte;
   int n_checks = 0, n_fail = 0;
   int err_cnt = 0, ovf_cnt = 0;
   int e0, o0;
   logic prev_err = 1'b0, prev_ovf = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Scoreboard monitor: compare the head whenever a real pop is presented.
   always @(negedge clk) begin
      if (rst_n && rd_en && !empty) begin
         if (sb.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL sb_pop: got 0x%0h expected no data", rd_data);
         end else begin
            exp_byte = sb.pop_front();
            check("rd_data", {24'h0, rd_data}, {24'h0, exp_byte});
         end
      end
      if (frame_err) begin
         err_cnt++;
         check("err_single", {31'h0, prev_err}, 32'h0);
      end
      if (overflow) begin
         ovf_cnt++;
         check("ovf_single", {31'h0, prev_ovf}, 32'h0);
      end
      prev_err = frame_err;
      prev_ovf = overflow;
   end

   task automatic send(input logic [7:0] b);
      @(posedge clk); #1;
      rx_byte = b;
      rx_done = 1'b1;
      @(posedge clk); #1;
      rx_done = 1'b0;
      rx_byte = 8'h00;
   endtask

   task automatic frame(input logic [7:0] b);
      send(HDR);
      send(b);
   endtask

   task automatic pop_one();
      @(posedge clk); #1;
      rd_en = 1'b1;
      @(posedge clk); #1;
      rd_en = 1'b0;
   endtask

   task automatic settle();
      repeat (2) @(negedge clk);
   endtask

   task automatic do_reset();
      @(posedge clk); #1;
      rst_n = 1'b0;
      sb.delete();
      @(posedge clk); #1;
      rst_n = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time budget");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset state
      do_reset();
      @(negedge clk);
      check("rst_empty", {31'h0, empty}, 32'h1);
      check("rst_full", {31'h0, full}, 32'h0);
      check("rst_rd_data", {24'h0, rd_data}, 32'h0);
      check("rst_last", {24'h0, last_payload}, 32'h0);
      check("rst_count", {16'h0, frame_count}, 32'h0);
      check("rst_err", {31'h0, frame_err}, 32'h0);

      // 1: basic frame, FWFT latency, pop, pop-when-empty
      send(HDR);
      sb.push_back(8'h41);
      @(posedge clk); #1;
      rx_byte = 8'h41;
      rx_done = 1'b1;
      check("t1_empty_during", {31'h0, empty}, 32'h1);
      @(posedge clk); #1;
      rx_done = 1'b0;
      check("t1_empty_after", {31'h0, empty}, 32'h0);
      check("t1_head", {24'h0, rd_data}, 32'h41);
      check("t1_last", {24'h0, last_payload}, 32'h41);
      check("t1_count", {16'h0, frame_count}, 32'h1);
      pop_one();
      check("t1_empty_pop", {31'h0, empty}, 32'h1);
      pop_one();
      check("t1_empty_pop2", {31'h0, empty}, 32'h1);
      check("t1_rd_data_zero", {24'h0, rd_data}, 32'h0);

      // 2: stray byte then valid frame
      do_reset();
      e0 = err_cnt;
      send(8'h55);
      settle();
      check("t2_err_stray", err_cnt, e0 + 1);
      sb.push_back(8'h30);
      frame(8'h30);
      settle();
      check("t2_err_frame", err_cnt, e0 + 1);
      check("t2_count", {16'h0, frame_count}, 32'h1);
      check("t2_head", {24'h0, rd_data}, 32'h30);
      pop_one();

      // 3: payload timeout, recovery, and payload on the last allowed cycle
      do_reset();
      e0 = err_cnt;
      send(HDR);
      repeat (TO - 1) @(posedge clk);
      #1;
      check("t3_no_err_yet", {31'h0, frame_err}, 32'h0);
      @(posedge clk); #1;
      check("t3_timeout_err", {31'h0, frame_err}, 32'h1);
      settle();
      check("t3_err_cnt", err_cnt, e0 + 1);
      sb.push_back(8'h7A);
      frame(8'h7A);
      settle();
      check("t3_last", {24'h0, last_payload}, 32'h7A);
      pop_one();
      send(HDR);
      repeat (TO - 2) @(posedge clk);
      sb.push_back(8'h5E);
      send(8'h5E);
      settle();
      check("t3_edge_no_err", err_cnt, e0 + 1);
      check("t3_edge_last", {24'h0, last_payload}, 32'h5E);
      check("t3_edge_count", {16'h0, frame_count}, 32'h2);
      pop_one();

      // 4: fill to full, overflow on 9th, drain in order
      do_reset();
      o0 = ovf_cnt;
      for (int n = 0; n < 8; n++) begin
         sb.push_back(8'(n));
         frame(8'(n));
         if (n == 6) check("t4_not_full_7", {31'h0, full}, 32'h0);
      end
      check("t4_full_8", {31'h0, full}, 32'h1);
      frame(8'h08);
      settle();
      check("t4_ovf", ovf_cnt, o0 + 1);
      check("t4_last", {24'h0, last_payload}, 32'h08);
      check("t4_count", {16'h0, frame_count}, 32'h9);
      repeat (8) pop_one();
      check("t4_drained", {31'h0, empty}, 32'h1);

      // 5: full FIFO with pop coincident with payload push, pointers wrap
      for (int n = 0; n < 8; n++) begin
         sb.push_back(8'h10 + 8'(n));
         frame(8'h10 + 8'(n));
      end
      check("t5_full", {31'h0, full}, 32'h1);
      o0 = ovf_cnt;
      send(HDR);
      sb.push_back(8'h18);
      @(posedge clk); #1;
      rx_byte = 8'h18;
      rx_done = 1'b1;
      rd_en = 1'b1;
      @(posedge clk); #1;
      rx_done = 1'b0;
      rd_en = 1'b0;
      settle();
      check("t5_no_ovf", ovf_cnt, o0);
      check("t5_still_full", {31'h0, full}, 32'h1);
      check("t5_count", {16'h0, frame_count}, 32'd18);
      repeat (8) pop_one();
      check("t5_drained", {31'h0, empty}, 32'h1);

      // 6: reset between header and payload
      do_reset();
      frame(8'h22);
      send(HDR);
      @(posedge clk); #1;
      rst_n = 1'b0;
      sb.delete();
      #2;
      check("t6_empty", {31'h0, empty}, 32'h1);
      check("t6_full", {31'h0, full}, 32'h0);
      check("t6_rd_data", {24'h0, rd_data}, 32'h0);
      check("t6_last", {24'h0, last_payload}, 32'h0);
      check("t6_count", {16'h0, frame_count}, 32'h0);
      check("t6_err", {31'h0, frame_err}, 32'h0);
      check("t6_ovf", {31'h0, overflow}, 32'h0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      e0 = err_cnt;
      send(8'h22);
      settle();
      check("t6_stray_err", err_cnt, e0 + 1);
      check("t6_empty_after", {31'h0, empty}, 32'h1);
      check("t6_count_after", {16'h0, frame_count}, 32'h0);

      check("sb_leftover", sb.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
